// File: rtl/tt_uio_pkg.sv
// Shared types and constants for the uio pin arbiter family.
package tt_uio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

    localparam int                 UIO_W    = 8;
    localparam logic [UIO_W-1:0]   OE_DRIVE = 8'hFF;
    localparam logic [UIO_W-1:0]   OE_HIZ   = 8'h00;

    function automatic logic [UIO_W-1:0] oe_for(input logic drive);
        return drive ? OE_DRIVE : OE_HIZ;
    endfunction

endpackage

// File: rtl/tt_uio_arbiter_if.sv
// Requester and pin-side signals of the uio arbiter, bundled for port lists.
interface tt_uio_arbiter_if #(
    parameter int NREQ = 4
);
    import tt_uio_pkg::*;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       dir;
    logic [UIO_W*NREQ-1:0] wdata;
    logic [NREQ-1:0]       grant;
    logic [UIO_W-1:0]      rdata;
    logic [UIO_W-1:0]      uio_in;
    logic [UIO_W-1:0]      uio_out;
    logic [UIO_W-1:0]      uio_oe;

    // master: user logic plus pad side; slave: the arbiter itself
    modport master (
        output req, dir, wdata, uio_in,
        input  grant, rdata, uio_out, uio_oe
    );

    modport slave (
        input  req, dir, wdata, uio_in,
        output grant, rdata, uio_out, uio_oe
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above
// rr_ptr_i, wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);

    localparam int CW = IDX_W + 1;

    logic [CW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_i} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
                valid_o = 1'b1;
                index_o = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tt_uio_arbiter.sv
// Round-robin owner of the eight uio pins with a Hi-Z turnaround between
// owners and a hold limit that only bites when someone else is waiting.
//
// state | meaning
// IDLE  | pins released, waiting for ena and a request
// TURN  | winner latched, pins kept Hi-Z for TURNAROUND cycles
// OWN   | winner drives or reads the pins, hold timer running
module tt_uio_arbiter
    import tt_uio_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena_i,
    tt_uio_arbiter_if.slave bus,
    output logic            busy_o,
    output logic            timeout_o
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int TURN_W = 3;
    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);

    // both timers count down to a zero terminal count
    localparam logic [TURN_W-1:0] TURN_LOAD = (TURNAROUND > 0) ? TURN_W'(TURNAROUND - 1) : '0;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              dir_q, dir_d;
    logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [UIO_W-1:0]  oe_q, oe_d;
    logic [UIO_W-1:0]  out_q, out_d;
    logic [UIO_W-1:0]  rdata_q;
    logic              timeout_q, timeout_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  own_idx;
    logic [NREQ-1:0]   own_mask;
    logic [UIO_W-1:0]  sel_wdata;
    logic              sel_dir;
    logic              forced;
    logic              drop_own;
    logic              enter_own;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid),
        .index_o  (pick_idx)
    );

    // in IDLE the candidate is the fresh pick, otherwise the latched winner
    always_comb begin
        own_idx           = (state_q == IDLE) ? pick_idx : win_q;
        own_mask          = '0;
        own_mask[own_idx] = 1'b1;
        sel_wdata         = '0;
        sel_dir           = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (own_idx == IDX_W'(i)) begin
                sel_wdata = bus.wdata[i*UIO_W +: UIO_W];
                sel_dir   = bus.dir[i];
            end
        end
    end

    assign forced   = (MAX_HOLD != 0) && (hold_cnt_q == '0) && ((bus.req & ~own_mask) != '0);
    assign drop_own = !bus.req[win_q] || !ena_i || forced;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        dir_d      = dir_q;
        rr_ptr_d   = rr_ptr_q;
        turn_cnt_d = turn_cnt_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        oe_d       = oe_q;
        out_d      = out_q;
        timeout_d  = 1'b0;
        enter_own  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ena_i && pick_valid) begin
                    win_d = pick_idx;
                    dir_d = sel_dir;
                    if (TURNAROUND == 0) begin
                        enter_own = 1'b1;
                    end else begin
                        state_d    = TURN;
                        turn_cnt_d = TURN_LOAD;
                    end
                end
            end
            TURN: begin
                if (!ena_i) begin
                    state_d = IDLE;
                end else if (turn_cnt_q == '0) begin
                    enter_own = 1'b1;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end
            OWN: begin
                if (drop_own) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    oe_d      = OE_HIZ;
                    out_d     = '0;
                    rr_ptr_d  = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    timeout_d = forced && bus.req[win_q] && ena_i;
                end else begin
                    out_d = sel_wdata;
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_own) begin
            state_d    = OWN;
            grant_d    = own_mask;
            oe_d       = oe_for(dir_d);
            out_d      = sel_wdata;
            hold_cnt_d = HOLD_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            win_q      <= '0;
            dir_q      <= 1'b0;
            rr_ptr_q   <= '0;
            turn_cnt_q <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            oe_q       <= OE_HIZ;
            out_q      <= '0;
            rdata_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            dir_q      <= dir_d;
            rr_ptr_q   <= rr_ptr_d;
            turn_cnt_q <= turn_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            rdata_q    <= bus.uio_in;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.uio_oe  = oe_q;
    assign bus.uio_out = out_q;
    assign bus.rdata   = rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign timeout_o   = timeout_q;

endmodule

// File: doc/tt_uio_arbiter.md
Name: tt_uio_arbiter

Overview:
- Arbitrates the eight bidirectional uio pins of the tt_um_* top level among NREQ internal requesters.
- Sits between the user logic and the uio_in/uio_out/uio_oe top ports.
- Grants exclusive, round-robin ownership of the pins. Inserts a guaranteed high-impedance turnaround between owners so that two drivers never overlap.
- Enforces a maximum hold time when other requesters are waiting.

Parameters:
- NREQ, 4: number of requesters (2..8).
- TURNAROUND, 1: cycles with uio_oe forced to 0 before each new grant (0..7).
- MAX_HOLD, 16: maximum OWN cycles while another request is pending. 0 means unlimited.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design-selected enable from the tt_um_* top level
- req  in  NREQ  per-requester request level, held high for the whole transaction
- dir  in  NREQ  per-requester direction: 1 = drive pins, 0 = read pins. Sampled at grant.
- wdata  in  8*NREQ  per-requester output byte; slice i is bits [8i+7:8i]
- uio_in  in  8  pin input path
- grant  out  NREQ  one-hot ownership indicator
- rdata  out  8  registered sample of uio_in
- uio_out  out  8  pin output path
- uio_oe  out  8  pin output enable
- busy  out  1  high in TURN or OWN
- timeout  out  1  one-cycle pulse on a forced release

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous on rst_n low; release is taken on a clk edge.
  - Reset values: grant=0, uio_oe=0, uio_out=0, rdata=0, busy=0, timeout=0, state=IDLE, rr_ptr=0.
  - Reset mid-transaction drops all outputs immediately.
- State machine, IDLE / TURN / OWN:
  - IDLE to TURN: ena=1 and any req bit set. Winner is the first set req bit searching upward from rr_ptr, with wrap. Winner index and its dir bit are latched. If TURNAROUND=0, IDLE goes directly to OWN.
  - TURN: counts TURNAROUND cycles with uio_oe=0 and grant=0, then goes to OWN.
  - On entry to OWN, at the same edge:
    - grant[w] is set.
    - uio_oe is loaded with 8'hFF if the latched dir=1, else 8'h00.
    - uio_out is loaded with wdata slice w.
  - OWN, each cycle: uio_out is re-registered from slice w, giving one-cycle latency from wdata to the pin.
  - dir changes during OWN are ignored.
  - OWN to IDLE happens when any of these is sampled:
    - req[w]=0 (release), or
    - ena=0, or
    - the hold counter reaches MAX_HOLD while another req bit is set. This is a forced release and pulses timeout for one cycle.
  - On leaving OWN, at that edge: grant=0, uio_oe=0, uio_out=0, rr_ptr=(w+1) mod NREQ.
- Bus-idle gap: the minimum gap between two owners is TURNAROUND+1 cycles (the IDLE cycle plus TURN).
- Hold counter:
  - Cleared on entry to OWN; increments each OWN cycle.
  - Saturates when no competitor is pending. A lone requester is never timed out.
- rdata: rdata <= uio_in every cycle in every state, one-cycle latency. The value is meaningful only while the owner has dir=0.
- ena:
  - ena=0 in IDLE blocks new grants.
  - ena=0 in TURN aborts to IDLE and does not advance rr_ptr.
- Requester behaviour:
  - A requester that drops req during TURN: the grant is still completed, then released on the first OWN cycle.
  - Simultaneous release and a new request from the same requester: the requester is released, and rr_ptr favours the others.

Decomposition:
- Shared package tt_uio_pkg holds:
  - the state enum (IDLE, TURN, OWN);
  - the constants UIO_W=8, OE_DRIVE=8'hFF, OE_HIZ=8'h00.
- One sub-module, rr_pick: a combinational round-robin priority encoder with inputs (req, rr_ptr) and outputs (valid, index). It is reused by later arbiters.

Test Plan:
1. Reset then a single requester.
   - Stimulus: hold rst_n=0 for 5 cycles, then release. Raise req=4'b0010, dir=4'b0010, wdata slice1=8'hA5.
   - Required: grant=4'b0010 and uio_oe=8'hFF appear 2 cycles after req is sampled (TURNAROUND=1). uio_out=8'hA5.
2. Round-robin.
   - Stimulus: hold req=4'b1111 and drop each owner's req after 3 OWN cycles.
   - Required: grant order 0,1,2,3,0, with uio_oe=0 for at least 2 cycles between owners.
3. Timeout.
   - Stimulus: req0 held forever, req2 raised.
   - Required: after 16 OWN cycles timeout pulses once, grant0 drops, and grant2 follows after the gap. A lone req0 never times out.
4. Read direction.
   - Stimulus: requester 3 with dir=0, uio_in=8'h3C.
   - Required: uio_oe=8'h00 and rdata=8'h3C one cycle after uio_in is applied. Toggling dir mid-OWN leaves uio_oe unchanged.
5. Reset mid-OWN.
   - Stimulus: assert rst_n=0 asynchronously between edges.
   - Required: grant, uio_oe, uio_out and busy go to 0 without waiting for a clk edge. After release, arbitration restarts from requester 0.
6. ena low.
   - Stimulus: deassert ena during OWN.
   - Required: the owner is released next edge and no new grant occurs while ena=0.
